// File: rtl/mul_acc_window.sv
// Windowed saturating accumulator for the multiplier product stream.
// Sums WIN qualified products per window and presents each sum on a single-entry valid/ready register.
module mul_acc_window #(
  parameter int P_W   = 16,
  parameter int ACC_W = 24,
  parameter int WIN   = 128,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iAEn,
  input  logic [P_W-1:0]   iP,
  input  logic             iClr,
  input  logic             iRdy,
  output logic             oVld,
  output logic [ACC_W-1:0] oAcc,
  output logic             oSat,
  output logic             oDrop,
  output logic [15:0]      oCnt
);

  logic [LAT-1:0]   dly;
  logic [15:0]      cnt;
  logic [ACC_W-1:0] acc;
  logic             satf;

  logic             qual;
  logic             last;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   wide;
  logic             ovf;
  logic [ACC_W-1:0] sum_acc;
  logic             sum_sat;

  assign qual = dly[LAT-1];
  assign oCnt = cnt;

  // First product of a window adds to zero, so it can never overflow and starts a clean sat flag.
  always_comb begin
    ext     = ACC_W'(signed'(iP));
    base    = (cnt == '0) ? '0 : acc;
    last    = (cnt == 16'(WIN - 1));
    wide    = {base[ACC_W-1], base} + {ext[ACC_W-1], ext};
    ovf     = wide[ACC_W] ^ wide[ACC_W-1];
    sum_acc = wide[ACC_W-1:0];
    if (ovf) begin
      sum_acc = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    sum_sat = ((cnt != '0) && satf) || ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly <= '0;
    end else if (iClr) begin
      dly <= '0;
    end else begin
      dly[0] <= iAEn;
      for (int unsigned i = 1; i < LAT; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      acc  <= '0;
      satf <= 1'b0;
    end else if (iClr) begin
      cnt  <= '0;
      acc  <= '0;
      satf <= 1'b0;
    end else if (qual) begin
      acc  <= sum_acc;
      satf <= sum_sat;
      cnt  <= last ? '0 : cnt + 16'd1;
    end
  end

  // A completing window always loads; it only counts as a drop if the held result was not taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oVld  <= 1'b0;
      oAcc  <= '0;
      oSat  <= 1'b0;
      oDrop <= 1'b0;
    end else if (iClr) begin
      oVld  <= 1'b0;
      oSat  <= 1'b0;
      oDrop <= 1'b0;
    end else if (qual && last) begin
      oAcc <= sum_acc;
      oSat <= sum_sat;
      oVld <= 1'b1;
      if (oVld && !iRdy) begin
        oDrop <= 1'b1;
      end
    end else if (oVld && iRdy) begin
      oVld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mul_acc_window.sv
// Directed bench for mul_acc_window: default instance (WIN=128, ACC_W=24) and a small saturating one (WIN=4, ACC_W=16).
module tb_mul_acc_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_aen, a_clr, a_rdy;
  logic [15:0] a_p;
  logic        a_vld, a_sat, a_drop;
  logic [23:0] a_acc;
  logic [15:0] a_cnt;
  logic        b_aen, b_clr, b_rdy;
  logic [15:0] b_p;
  logic        b_vld, b_sat, b_drop;
  logic [15:0] b_acc;
  logic [15:0] b_cnt;

  int checks = 0;
  int errors = 0;

  // Operand history models the multiplier: the product of an operand shows up LAT=3 cycles later.
  logic        ea [0:3];
  logic [15:0] pa [0:3];
  logic        eb [0:3];
  logic [15:0] pb [0:3];

  always #5 clk = ~clk;

  mul_acc_window #(.P_W(16), .ACC_W(24), .WIN(128), .LAT(3)) dut_a (
    .clk(clk), .rst(rst), .iAEn(a_aen), .iP(a_p), .iClr(a_clr), .iRdy(a_rdy),
    .oVld(a_vld), .oAcc(a_acc), .oSat(a_sat), .oDrop(a_drop), .oCnt(a_cnt)
  );

  mul_acc_window #(.P_W(16), .ACC_W(16), .WIN(4), .LAT(3)) dut_b (
    .clk(clk), .rst(rst), .iAEn(b_aen), .iP(b_p), .iClr(b_clr), .iRdy(b_rdy),
    .oVld(b_vld), .oAcc(b_acc), .oSat(b_sat), .oDrop(b_drop), .oCnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit sel, input logic aen, input logic [15:0] p);
    if (!sel) begin
      for (int k = 3; k > 0; k--) begin
        ea[k] = ea[k-1];
        pa[k] = pa[k-1];
      end
      ea[0] = aen;
      pa[0] = p;
      a_aen = aen;
      a_p   = ea[3] ? pa[3] : 16'h7FFF;
    end else begin
      for (int k = 3; k > 0; k--) begin
        eb[k] = eb[k-1];
        pb[k] = pb[k-1];
      end
      eb[0] = aen;
      pb[0] = p;
      b_aen = aen;
      b_p   = eb[3] ? pb[3] : 16'h7FFF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit sel, input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) cyc(sel, 1'b1, p);
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) cyc(sel, 1'b0, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      ea[k] = 1'b0; pa[k] = '0; eb[k] = 1'b0; pb[k] = '0;
    end
    rst = 1'b0;
    a_aen = 1'b0; a_clr = 1'b0; a_rdy = 1'b1; a_p = '0;
    b_aen = 1'b0; b_clr = 1'b0; b_rdy = 1'b1; b_p = '0;
    #3;
    chk("rst_a_vld", 32'(a_vld), 32'h0);
    chk("rst_a_acc", 32'(a_acc), 32'h0);
    chk("rst_a_drop", 32'(a_drop), 32'h0);
    chk("rst_b_cnt", 32'(b_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Window of 128 ones
    run(0, 10, 16'h0001);
    chk("w1_cnt_mid", 32'(a_cnt), 32'd7);
    run(0, 118, 16'h0001);
    idle(0, 2);
    chk("w1_vld_early", 32'(a_vld), 32'h0);
    idle(0, 1);
    chk("w1_vld", 32'(a_vld), 32'h1);
    chk("w1_acc", 32'(a_acc), 32'd128);
    chk("w1_sat", 32'(a_sat), 32'h0);
    chk("w1_cnt", 32'(a_cnt), 32'h0);
    idle(0, 1);
    chk("w1_vld_one_cycle", 32'(a_vld), 32'h0);

    // Mixed signs, then all-negative window, back to back
    for (int i = 0; i < 256; i++) begin
      cyc(0, 1'b1, (i < 128 && (i % 2) == 0) ? 16'h4000 : 16'hC000);
      if (i == 130) begin
        chk("mix_vld", 32'(a_vld), 32'h1);
        chk("mix_acc", 32'(a_acc), 32'h0);
      end
    end
    idle(0, 3);
    chk("neg_vld", 32'(a_vld), 32'h1);
    chk("neg_acc", 32'(a_acc), 32'hE00000);
    chk("neg_sat", 32'(a_sat), 32'h0);
    idle(0, 1);

    // Gaps: unqualified cycles carry 0x7FFF on iP
    for (int i = 0; i < 128; i++) begin
      cyc(0, 1'b1, 16'h0001);
      if (i == 5 || i == 17 || i == 30 || i == 31 || i == 50 ||
          i == 63 || i == 77 || i == 90 || i == 101 || i == 120)
        cyc(0, 1'b0, 16'h0000);
    end
    idle(0, 3);
    chk("gap_vld", 32'(a_vld), 32'h1);
    chk("gap_acc", 32'(a_acc), 32'd128);
    idle(0, 1);

    // Backpressure: hold, same-cycle transfer, overwrite, clear
    a_rdy = 1'b0;
    run(0, 128, 16'h0001);
    idle(0, 3);
    chk("bp1_acc", 32'(a_acc), 32'd128);
    idle(0, 5);
    chk("bp1_hold_vld", 32'(a_vld), 32'h1);
    chk("bp1_hold_acc", 32'(a_acc), 32'd128);
    run(0, 128, 16'h0002);
    idle(0, 2);
    a_rdy = 1'b1;
    idle(0, 1);
    a_rdy = 1'b0;
    chk("bp2_vld", 32'(a_vld), 32'h1);
    chk("bp2_acc", 32'(a_acc), 32'd256);
    chk("bp2_drop", 32'(a_drop), 32'h0);
    run(0, 128, 16'h0003);
    idle(0, 3);
    chk("bp3_acc", 32'(a_acc), 32'd384);
    chk("bp3_drop", 32'(a_drop), 32'h1);
    a_clr = 1'b1;
    idle(0, 1);
    a_clr = 1'b0;
    chk("clr_drop", 32'(a_drop), 32'h0);
    chk("clr_vld", 32'(a_vld), 32'h0);
    chk("clr_acc_hold", 32'(a_acc), 32'd384);

    // Asynchronous reset mid-window with a result pending
    run(0, 128, 16'h0001);
    idle(0, 3);
    chk("prerst_vld", 32'(a_vld), 32'h1);
    run(0, 50, 16'h0001);
    rst = 1'b0;
    #1;
    chk("arst_vld", 32'(a_vld), 32'h0);
    chk("arst_acc", 32'(a_acc), 32'h0);
    chk("arst_drop", 32'(a_drop), 32'h0);
    chk("arst_cnt", 32'(a_cnt), 32'h0);
    #1;
    rst = 1'b1;
    a_rdy = 1'b1;
    run(0, 128, 16'h0005);
    idle(0, 3);
    chk("postrst_vld", 32'(a_vld), 32'h1);
    chk("postrst_acc", 32'(a_acc), 32'd640);
    idle(0, 1);

    // Small instance: saturation, recovery, clear mid-window
    run(1, 4, 16'h7FFF);
    idle(1, 3);
    chk("sat_pos_vld", 32'(b_vld), 32'h1);
    chk("sat_pos_acc", 32'(b_acc), 32'h7FFF);
    chk("sat_pos_flag", 32'(b_sat), 32'h1);
    run(1, 4, 16'h0001);
    idle(1, 3);
    chk("sat_rec_acc", 32'(b_acc), 32'd4);
    chk("sat_rec_flag", 32'(b_sat), 32'h0);
    run(1, 4, 16'h8000);
    idle(1, 3);
    chk("sat_neg_acc", 32'(b_acc), 32'h8000);
    chk("sat_neg_flag", 32'(b_sat), 32'h1);
    run(1, 2, 16'h0001);
    idle(1, 3);
    chk("bclr_cnt_pre", 32'(b_cnt), 32'd2);
    b_clr = 1'b1;
    idle(1, 1);
    b_clr = 1'b0;
    chk("bclr_cnt", 32'(b_cnt), 32'h0);
    chk("bclr_vld", 32'(b_vld), 32'h0);
    run(1, 4, 16'h0003);
    idle(1, 3);
    chk("bclr_next_vld", 32'(b_vld), 32'h1);
    chk("bclr_next_acc", 32'(b_acc), 32'd12);
    chk("bclr_next_sat", 32'(b_sat), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
